// File: rtl/tt_lut_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------------------------
// tt_lut_engine : run-time loadable 2^N_IN x N_OUT truth table with registered lookup
// Revision      : 1.0
// ------------------------------------------------------------------------------------
module tt_lut_engine #(
  parameter int              N_IN        = 3,
  parameter int              N_OUT       = 2,
  parameter logic [N_OUT-1:0] DEFAULT_OUT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  input  logic [N_OUT-1:0] cfg_data,
  output logic             cfg_ready,
  output logic             cfg_done,
  input  logic             in_valid,
  input  logic [N_IN-1:0]  in_vec,
  output logic             in_ready,
  output logic             out_valid,
  output logic [N_OUT-1:0] out_vec,
  output logic             out_hit,
  input  logic             out_ready,
  output logic             busy
);

  localparam int            DEPTH    = 1 << N_IN;
  localparam logic [N_IN:0] LAST_PTR = (N_IN + 1)'(DEPTH - 1);
  localparam logic [N_IN:0] PTR_ONE  = (N_IN + 1)'(1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t           state;
  logic [N_IN:0]    ptr;
  logic [N_OUT-1:0] tbl [DEPTH];
  logic             accept;

  // Readies depend only on registered state and out_ready, never on the valids.
  assign cfg_ready = (state == LOAD);
  assign busy      = (state == LOAD);
  assign in_ready  = (state != LOAD) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_vec   <= DEFAULT_OUT;
      out_hit   <= 1'b0;
      cfg_done  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= DEFAULT_OUT;
      end
    end else begin
      cfg_done <= 1'b0;

      // Lookup uses the table as it stands before any same-cycle cfg_start.
      if (accept) begin
        out_vec   <= (state == READY) ? tbl[in_vec] : DEFAULT_OUT;
        out_hit   <= (state == READY);
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        LOAD: begin
          if (cfg_start) begin
            ptr <= '0;
          end else if (cfg_valid) begin
            tbl[ptr[N_IN-1:0]] <= cfg_data;
            ptr                <= ptr + PTR_ONE;
            if (ptr == LAST_PTR) begin
              state    <= READY;
              cfg_done <= 1'b1;
            end
          end
        end
        default: begin
          if (cfg_start) begin
            state <= LOAD;
            ptr   <= '0;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tt_lut_engine.sv
`timescale 1ns/1ps
`default_nettype none
// tb_tt_lut_engine : directed plus randomized checks against a behavioural truth-table model.
module tb_tt_lut_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_start = 1'b0, cfg_valid = 1'b0;
  logic [1:0] cfg_data = '0;
  logic       cfg_ready, cfg_done;
  logic       in_valid = 1'b0;
  logic [2:0] in_vec = '0;
  logic       in_ready, out_valid, out_hit, busy;
  logic [1:0] out_vec;
  logic       out_ready = 1'b1;

  tt_lut_engine #(.N_IN(3), .N_OUT(2), .DEFAULT_OUT(2'b00)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .cfg_done(cfg_done),
    .in_valid(in_valid), .in_vec(in_vec), .in_ready(in_ready),
    .out_valid(out_valid), .out_vec(out_vec), .out_hit(out_hit),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  // Behavioural model: what has been loaded, how many entries so far, what is pending.
  logic [1:0] m_tbl [8];
  bit         m_loading, m_programmed, m_valid, m_hit, m_done;
  logic [1:0] m_vec;
  int         m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_tbl[i] = 2'b00;
    m_loading = 0; m_programmed = 0; m_valid = 0; m_hit = 0; m_done = 0;
    m_vec = 2'b00; m_cnt = 0;
  endtask

  // One clock cycle: drive, check readies, advance model, check registered outputs.
  task automatic cyc(input bit cs, input bit cv, input logic [1:0] cd,
                     input bit iv, input logic [2:0] ivec, input bit ordy);
    bit e_ir;
    cfg_start = cs; cfg_valid = cv; cfg_data = cd;
    in_valid = iv; in_vec = ivec; out_ready = ordy;
    #1;
    e_ir = !m_loading && (!m_valid || ordy);
    chk("in_ready", in_ready, e_ir);
    chk("cfg_ready", cfg_ready, m_loading);
    chk("busy", busy, m_loading);
    m_done = 0;
    if (iv && e_ir) begin
      m_vec   = m_programmed ? m_tbl[ivec] : 2'b00;
      m_hit   = m_programmed;
      m_valid = 1;
    end else if (ordy) begin
      m_valid = 0;
    end
    if (m_loading) begin
      if (cs) m_cnt = 0;
      else if (cv) begin
        m_tbl[m_cnt] = cd;
        m_cnt++;
        if (m_cnt == 8) begin
          m_loading = 0; m_programmed = 1; m_done = 1;
        end
      end
    end else if (cs) begin
      m_loading = 1; m_cnt = 0;
    end
    @(posedge clk); #1;
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("out_vec", out_vec, m_vec);
      chk("out_hit", out_hit, m_hit);
    end
    chk("cfg_done", cfg_done, m_done);
    if (cfg_done) done_seen++;
  endtask

  initial begin
    logic [1:0] first_tbl [8];
    int d0;
    first_tbl = '{2'd2, 2'd3, 2'd3, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3};
    model_reset();

    // Reset state
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_vec", out_vec, 0);
    chk("rst_out_hit", out_hit, 0);
    chk("rst_cfg_done", cfg_done, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Evaluate while EMPTY
    cyc(0, 0, 0, 1, 5, 1);
    chk("empty_valid", out_valid, 1);
    chk("empty_vec", out_vec, 0);
    chk("empty_hit", out_hit, 0);
    cyc(0, 0, 0, 0, 0, 1);

    // Full load 2,3,3,1,3,3,3,3; cfg_done in cycle 9
    d0 = done_seen;
    cyc(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(0, 1, first_tbl[i], 0, 0, 1);
    chk("done_cycle9", cfg_done, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("done_once", done_seen - d0, 1);

    // Sweep at full throughput
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 1, 3'(i), 1);
      chk("sweep_vec", out_vec, first_tbl[i]);
      chk("sweep_hit", out_hit, 1);
    end
    cyc(0, 0, 0, 0, 0, 1);

    // Backpressure hold, then no-bubble release
    cyc(0, 0, 0, 1, 3, 1);
    chk("hold_first", out_vec, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1, 5, 0);
      chk("hold_vec", out_vec, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    cyc(0, 0, 0, 1, 5, 1);
    chk("release_vec", out_vec, 3);
    chk("release_valid", out_valid, 1);
    cyc(0, 0, 0, 0, 0, 1);

    // cfg_start coincident with evaluation in READY
    cyc(1, 0, 0, 1, 0, 1);
    chk("coinc_vec", out_vec, 2);
    chk("coinc_hit", out_hit, 1);
    chk("coinc_busy", busy, 1);

    // Reload restarted after 3 entries
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 2'd0, 1, 2, 1);
      chk("load_in_ready", in_ready, 0);
    end
    cyc(1, 0, 0, 1, 2, 1);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 2'(i), 1, 7, 1);
      if (i < 7) chk("load_in_ready", in_ready, 0);
    end
    cyc(0, 0, 0, 1, 6, 1);
    chk("reload_vec", out_vec, 2);
    chk("reload_hit", out_hit, 1);
    cyc(0, 0, 0, 0, 0, 1);

    // Reset mid-load
    cyc(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 2'd3, 0, 0, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_cfg_ready", cfg_ready, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    model_reset();
    #3;
    rst_n = 1'b1;
    cyc(0, 0, 0, 1, 1, 1);
    chk("abort_eval_vec", out_vec, 0);
    chk("abort_eval_hit", out_hit, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0), 2'($urandom),
          ($urandom_range(0, 3) != 0), 3'($urandom), ($urandom_range(0, 3) != 0));
    end
    cyc(0, 0, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
